// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the SDRAM command-port arbiter.
package sdram_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int N_DEFAULT        = 2;
    localparam int AW_DEFAULT       = 24;
    localparam int DW_DEFAULT       = 16;
    localparam int LW_DEFAULT       = 8;
    localparam int TAGDEPTH_DEFAULT = 8;

    // A requester index needs at least one bit, even when N is 2 or less.
    function automatic int tag_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side and controller-side signals of the arbiter, bundled as one bus.
interface sdram_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT,
    parameter int LW = LW_DEFAULT
);

    logic [N-1:0]    rq_valid;
    logic [N-1:0]    rq_ready;
    logic [N-1:0]    rq_we;
    logic [N*AW-1:0] rq_addr;
    logic [N*LW-1:0] rq_len;
    logic [N*DW-1:0] rq_wdata;
    logic [N-1:0]    rq_wready;
    logic [DW-1:0]   rd_data;
    logic [N-1:0]    rd_valid;
    logic            mem_valid;
    logic            mem_ready;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic            err_tag;

    // The arbiter's view.
    modport slave (
        input  rq_valid, rq_we, rq_addr, rq_len, rq_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output rq_ready, rq_wready, rd_data, rd_valid,
        output mem_valid, mem_we, mem_addr, mem_wdata, err_tag
    );

    // The requesters' and controller's view.
    modport master (
        output rq_valid, rq_we, rq_addr, rq_len, rq_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  rq_ready, rq_wready, rd_data, rd_valid,
        input  mem_valid, mem_we, mem_addr, mem_wdata, err_tag
    );

endinterface

// File: rtl/tag_fifo.sv
// Synchronous FIFO of requester tags for reads in flight; pushes while full and pops while empty are ignored.
module tag_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PW-1:0]];

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin, burst-granular arbiter for the single SDRAM controller command port.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int AW       = AW_DEFAULT,
    parameter int DW       = DW_DEFAULT,
    parameter int LW       = LW_DEFAULT,
    parameter int TAGDEPTH = TAGDEPTH_DEFAULT
) (
    input logic            clk,
    input logic            n_reset,
    sdram_arbiter_if.slave bus
);

    localparam int GW = tag_width(N);

    state_t        state;
    state_t        state_nxt;
    logic [GW-1:0] last;
    logic [GW-1:0] gnt;
    logic [GW-1:0] sel;
    logic          found;
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic [LW-1:0] cnt;
    logic          we;
    logic          err_q;

    logic          cmd_valid;
    logic          hs;
    logic          last_beat;
    logic          tag_full;
    logic          tag_empty;
    logic [GW-1:0] tag_out;

    // A read never issues while the tag FIFO is full, even if a return frees a slot this cycle.
    assign cmd_valid = (state == BURST) && !(!we && tag_full);
    assign hs        = cmd_valid && bus.mem_ready;
    assign last_beat = (cnt == len);

    // Search starts just after the last granted requester, so the most recent winner ranks lowest.
    always_comb begin
        // NOTE: defaults before the loop keep this purely combinational (no latches).
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found && bus.rq_valid[(int'(last) + k) % N]) begin
                found = 1'b1;
                sel   = GW'((int'(last) + k) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)            state_nxt = BURST;
            BURST:   if (hs && last_beat)  state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.rq_ready  = '0;
        bus.rq_wready = '0;
        bus.rd_valid  = '0;
        bus.rd_data   = '0;
        bus.mem_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.err_tag   = err_q;
        if (state == IDLE && found) bus.rq_ready[sel] = 1'b1;
        if (state == BURST) begin
            bus.mem_valid = cmd_valid;
            bus.mem_we    = we;
            bus.mem_addr  = base + AW'(cnt);
            bus.mem_wdata = bus.rq_wdata[int'(gnt)*DW +: DW];
            if (hs && we) bus.rq_wready[gnt] = 1'b1;
        end
        if (bus.mem_rvalid && !tag_empty) begin
            bus.rd_valid[tag_out] = 1'b1;
            bus.rd_data           = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            last  <= GW'(N - 1);
            gnt   <= '0;
            base  <= '0;
            len   <= '0;
            we    <= 1'b0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                gnt  <= sel;
                base <= bus.rq_addr[int'(sel)*AW +: AW];
                len  <= bus.rq_len[int'(sel)*LW +: LW];
                we   <= bus.rq_we[sel];
                cnt  <= '0;
            end else if (hs) begin
                if (last_beat) begin
                    last <= gnt;
                    cnt  <= '0;
                end else begin
                    cnt  <= cnt + 1'b1;
                end
            end
            if (bus.mem_rvalid && tag_empty) err_q <= 1'b1;
        end
    end

    tag_fifo #(
        .W     (GW),
        .DEPTH (TAGDEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (hs && !we),
        .pop     (bus.mem_rvalid),
        .din     (gnt),
        .dout    (tag_out),
        .full    (tag_full),
        .empty   (tag_empty)
    );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: grant order, burst addressing, stalls, read routing and reset.
module tb_sdram_arbiter;

    localparam int N        = 2;
    localparam int AW       = 24;
    localparam int DW       = 16;
    localparam int LW       = 8;
    localparam int TAGDEPTH = 8;

    logic clk = 1'b0;
    logic n_reset;
    int   checks   = 0;
    int   failures = 0;

    sdram_arbiter_if #(.N(N), .AW(AW), .DW(DW), .LW(LW)) bus ();

    sdram_arbiter #(
        .N(N), .AW(AW), .DW(DW), .LW(LW), .TAGDEPTH(TAGDEPTH)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        bus.rq_we[i]             = w;
        bus.rq_addr[i*AW +: AW]  = a;
        bus.rq_len[i*LW +: LW]   = l;
        bus.rq_valid[i]          = 1'b1;
    endtask

    // Raise one request in an IDLE cycle, expect the grant, then drop it after the edge.
    task automatic request(input int i, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        logic [N-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        @(negedge clk);
        set_req(i, w, a, l);
        #1;
        check("rq_ready_grant", bus.rq_ready, oh);
        @(posedge clk);
        #1;
        bus.rq_valid[i] = 1'b0;
    endtask

    task automatic write_burst(input int i, input logic [AW-1:0] a, input int beats, input logic toggle);
        logic [N-1:0]  oh;
        logic [AW-1:0] ea;
        int            beat;
        oh    = '0;
        oh[i] = 1'b1;
        beat  = 0;
        request(i, 1'b1, a, LW'(beats - 1));
        for (int cyc = 0; cyc < 64 && beat < beats; cyc++) begin
            @(negedge clk);
            bus.mem_ready           = toggle ? (cyc % 2 == 1) : 1'b1;
            bus.rq_wdata[i*DW +: DW] = 16'hD000 + 16'(beat);
            #1;
            ea = a + AW'(beat);
            check("wr_mem_valid", bus.mem_valid, 1);
            check("wr_mem_we", bus.mem_we, 1);
            check("wr_mem_addr", bus.mem_addr, ea);
            check("wr_mem_wdata", bus.mem_wdata, 16'hD000 + 16'(beat));
            check("wr_rq_wready", bus.rq_wready, bus.mem_ready ? oh : '0);
            if (bus.mem_ready) beat++;
        end
        check("wr_beats_done", beat, beats);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        check("wr_idle_after", bus.mem_valid, 0);
        check("wr_no_grant_after", bus.rq_ready, 0);
    endtask

    initial begin
        logic [N-1:0]  exp_oh;
        logic [AW-1:0] q_a[$];
        int            q_t[$];
        int            grants, last_cyc, issued, returned;
        logic          hold, first_ret;

        bus.rq_valid   = '0;
        bus.rq_we      = '0;
        bus.rq_addr    = '0;
        bus.rq_len     = '0;
        bus.rq_wdata   = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        n_reset        = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("reset_mem_valid", bus.mem_valid, 0);
        check("reset_mem_addr", bus.mem_addr, 0);
        check("reset_rq_ready", bus.rq_ready, 0);
        check("reset_rd_valid", bus.rd_valid, 0);
        check("reset_err_tag", bus.err_tag, 0);
        n_reset = 1'b1;

        // Two writers contend with single-beat bursts; last pointer starts at N-1 so rq0 wins first.
        @(negedge clk);
        bus.mem_ready = 1'b1;
        set_req(0, 1'b1, 24'h000010, 8'd0);
        set_req(1, 1'b1, 24'h000020, 8'd0);
        grants   = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 20 && grants < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (bus.rq_ready != '0) begin
                exp_oh = (grants % 2 == 0) ? 2'b01 : 2'b10;
                check("rr_grant", bus.rq_ready, exp_oh);
                if (grants > 0) check("rr_gap", cyc - last_cyc, 2);
                last_cyc = cyc;
                grants++;
            end
        end
        check("rr_grant_count", grants, 4);
        @(negedge clk);
        bus.rq_valid = '0;
        #1;
        check("rr_last_beat", bus.mem_valid, 1);
        @(negedge clk);
        #1;
        check("rr_idle", bus.mem_valid, 0);

        write_burst(0, 24'h000100, 4, 1'b0);
        write_burst(1, 24'hFFFFFE, 4, 1'b0);
        write_burst(0, 24'h000400, 6, 1'b1);

        // 16-beat read; returns held back until the tag FIFO fills, then arrive 3 cycles after issue.
        request(1, 1'b0, 24'h000200, 8'd15);
        bus.mem_ready = 1'b1;
        issued    = 0;
        returned  = 0;
        hold      = 1'b1;
        first_ret = 1'b1;
        for (int cyc = 0; cyc < 200 && returned < 16; cyc++) begin
            @(negedge clk);
            if (!hold && q_t.size() > 0 && q_t[0] + 3 <= cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = q_a[0][15:0] ^ 16'hA5A5;
                void'(q_a.pop_front());
                void'(q_t.pop_front());
            end else begin
                bus.mem_rvalid = 1'b0;
            end
            #1;
            if (cyc == 12) begin
                check("rd_stall_issued", issued, TAGDEPTH);
                check("rd_stall_valid", bus.mem_valid, 0);
                hold = 1'b0;
            end
            if (bus.mem_rvalid) begin
                check("rd_route", bus.rd_valid, 2'b10);
                check("rd_data", bus.rd_data, (16'h0200 + 16'(returned)) ^ 16'hA5A5);
                if (first_ret) begin
                    check("rd_full_blocks_push", bus.mem_valid, 0);
                    first_ret = 1'b0;
                end
                returned++;
            end
            if (bus.mem_valid && bus.mem_ready) begin
                check("rd_addr", bus.mem_addr, 24'h000200 + 24'(issued));
                check("rd_mem_we", bus.mem_we, 0);
                q_a.push_back(bus.mem_addr);
                q_t.push_back(cyc);
                issued++;
            end
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        check("rd_issued_total", issued, 16);
        check("rd_returned_total", returned, 16);
        check("rd_err_tag", bus.err_tag, 0);
        check("rd_idle_after", bus.mem_valid, 0);

        // Reset in the middle of a read burst with reads still outstanding.
        request(0, 1'b0, 24'h000300, 8'd15);
        bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        check("mid_reset_mem_valid", bus.mem_valid, 0);
        check("mid_reset_mem_addr", bus.mem_addr, 0);
        check("mid_reset_mem_we", bus.mem_we, 0);
        check("mid_reset_mem_wdata", bus.mem_wdata, 0);
        check("mid_reset_rq_ready", bus.rq_ready, 0);
        check("mid_reset_rq_wready", bus.rq_wready, 0);
        check("mid_reset_rd_valid", bus.rd_valid, 0);
        check("mid_reset_err_tag", bus.err_tag, 0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'h1234;
        #1;
        check("orphan_rd_valid", bus.rd_valid, 0);
        check("orphan_err_before_edge", bus.err_tag, 0);
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        check("orphan_err_tag", bus.err_tag, 1);
        @(negedge clk);
        #1;
        check("orphan_err_sticky", bus.err_tag, 1);
        check("orphan_idle", bus.mem_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
